// File: rtl/pid_ctrl_param_if.sv
// Bus between the heading-error source, the PID block and the drive logic.
// The master drives the error sample, forward speed and mode controls.
// The slave returns the registered wheel speeds and their update strobe.
interface pid_ctrl_param_if #(
  parameter int ERR_W   = 12,
  parameter int FRWRD_W = 10
) ();
  logic                      moving;
  logic                      err_vld;
  logic signed [ERR_W-1:0]   error;
  logic        [FRWRD_W-1:0] frwrd;
  logic                      i_en;
  logic        [FRWRD_W:0]   lft_spd;
  logic        [FRWRD_W:0]   rght_spd;
  logic                      spd_vld;

  modport master (
    output moving, err_vld, error, frwrd, i_en,
    input  lft_spd, rght_spd, spd_vld
  );

  modport slave (
    input  moving, err_vld, error, frwrd, i_en,
    output lft_spd, rght_spd, spd_vld
  );
endinterface

// File: rtl/pid_ctrl_param.sv
// Parametrised heading PID. It saturates the heading error and forms P, I and D terms,
// then splits the scaled sum into left and right wheel speeds around the forward speed.
// All datapath arithmetic is done in 32-bit signed so that no intermediate wraps at the
// default parameters. The integrator has anti-windup: it holds instead of overflowing.
module pid_ctrl_param #(
  parameter int ERR_W   = 12,
  parameter int SAT_W   = 10,
  parameter int FRWRD_W = 10,
  parameter int INT_W   = 15,
  parameter int I_SHIFT = 6,
  parameter int D_DEPTH = 3,
  parameter int P_COEFF = 16,
  parameter int D_COEFF = 7
) (
  input logic             clk,
  input logic             rst,
  pid_ctrl_param_if.slave bus
);

  localparam logic signed [31:0] SAT_MAX  = (32'sd1 <<< (SAT_W - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN  = -(32'sd1 <<< (SAT_W - 1));
  localparam logic signed [31:0] INT_MAX  = (32'sd1 <<< (INT_W - 1)) - 32'sd1;
  localparam logic signed [31:0] INT_MIN  = -(32'sd1 <<< (INT_W - 1));
  localparam logic signed [31:0] SPD_MAX  = (32'sd1 <<< FRWRD_W) - 32'sd1;
  localparam logic signed [31:0] DIFF_MAX = 32'sd127;
  localparam logic signed [31:0] DIFF_MIN = -32'sd128;

  // Clamp a signed value into [lo, hi].
  function automatic logic signed [31:0] clamp(input logic signed [31:0] v,
                                               input logic signed [31:0] lo,
                                               input logic signed [31:0] hi);
    logic signed [31:0] r;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    else r = v;
    return r;
  endfunction

  // Map a signed speed into the unsigned output range 0..SPD_MAX.
  function automatic logic [FRWRD_W:0] spd_clamp(input logic signed [31:0] v);
    logic signed [31:0] c;
    c = clamp(v, 32'sd0, SPD_MAX);
    return c[FRWRD_W:0];
  endfunction

  logic signed [SAT_W-1:0] hist_r [D_DEPTH];
  logic signed [INT_W-1:0] int_r;
  logic        [FRWRD_W:0] lft_spd_r;
  logic        [FRWRD_W:0] rght_spd_r;
  logic                    spd_vld_r;

  logic signed [31:0]      err_ext_s;
  logic signed [31:0]      sat_ext_s;
  logic signed [SAT_W-1:0] err_sat_s;
  logic signed [31:0]      hist_ext_s;
  logic signed [31:0]      int_ext_s;
  logic signed [31:0]      frwrd_ext_s;
  logic signed [31:0]      p_half_s;
  logic signed [31:0]      i_term_s;
  logic signed [31:0]      d_term_s;
  logic signed [31:0]      adj_s;
  logic signed [31:0]      int_sum_s;
  logic                    int_ovf_s;
  logic        [FRWRD_W:0] lft_nxt_s;
  logic        [FRWRD_W:0] rght_nxt_s;

  // PID datapath: saturate, form the P/I/D terms, and derive the clamped wheel speeds.
  always_comb begin
    err_ext_s   = {{(32 - ERR_W){bus.error[ERR_W-1]}}, bus.error};
    sat_ext_s   = clamp(err_ext_s, SAT_MIN, SAT_MAX);
    err_sat_s   = sat_ext_s[SAT_W-1:0];
    hist_ext_s  = {{(32 - SAT_W){hist_r[D_DEPTH-1][SAT_W-1]}}, hist_r[D_DEPTH-1]};
    int_ext_s   = {{(32 - INT_W){int_r[INT_W-1]}}, int_r};
    frwrd_ext_s = $signed({{(32 - FRWRD_W){1'b0}}, bus.frwrd});
    p_half_s    = (sat_ext_s * P_COEFF) >>> 1;
    if (bus.i_en) begin
      i_term_s = int_ext_s >>> I_SHIFT;
    end else begin
      i_term_s = 32'sd0;
    end
    d_term_s    = clamp(sat_ext_s - hist_ext_s, DIFF_MIN, DIFF_MAX) * D_COEFF;
    adj_s       = (p_half_s + i_term_s + d_term_s) >>> 3;
    lft_nxt_s   = spd_clamp(frwrd_ext_s + adj_s);
    rght_nxt_s  = spd_clamp(frwrd_ext_s - adj_s);
    int_sum_s   = int_ext_s + sat_ext_s;
    int_ovf_s   = (int_sum_s > INT_MAX) || (int_sum_s < INT_MIN);
  end

  // D history: shifts in the saturated error on every valid sample, even when not moving.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D_DEPTH; i++) hist_r[i] <= {SAT_W{1'b0}};
    end else if (bus.err_vld) begin
      hist_r[0] <= err_sat_s;
      for (int i = 1; i < D_DEPTH; i++) hist_r[i] <= hist_r[i-1];
    end else begin
      for (int i = 0; i < D_DEPTH; i++) hist_r[i] <= hist_r[i];
    end
  end

  // Integrator: cleared when stopped; accumulates only if the sum stays in range (anti-windup).
  always_ff @(posedge clk) begin
    if (rst) begin
      int_r <= {INT_W{1'b0}};
    end else if (!bus.moving) begin
      int_r <= {INT_W{1'b0}};
    end else if (bus.err_vld && bus.i_en && !int_ovf_s) begin
      int_r <= int_sum_s[INT_W-1:0];
    end else begin
      int_r <= int_r;
    end
  end

  // Registered outputs: stopping forces zero speeds, otherwise a valid sample loads new speeds.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_spd_r  <= {(FRWRD_W + 1){1'b0}};
      rght_spd_r <= {(FRWRD_W + 1){1'b0}};
      spd_vld_r  <= 1'b0;
    end else if (!bus.moving) begin
      lft_spd_r  <= {(FRWRD_W + 1){1'b0}};
      rght_spd_r <= {(FRWRD_W + 1){1'b0}};
      spd_vld_r  <= bus.err_vld;
    end else if (bus.err_vld) begin
      lft_spd_r  <= lft_nxt_s;
      rght_spd_r <= rght_nxt_s;
      spd_vld_r  <= 1'b1;
    end else begin
      lft_spd_r  <= lft_spd_r;
      rght_spd_r <= rght_spd_r;
      spd_vld_r  <= 1'b0;
    end
  end

  assign bus.lft_spd  = lft_spd_r;
  assign bus.rght_spd = rght_spd_r;
  assign bus.spd_vld  = spd_vld_r;

endmodule
